// File: rtl/truth_table_scanner.sv
// Purpose : steps an N_IN-bit vector through every combination, samples the
//           expression output y_in after SETTLE cycles, builds the truth table and minterm count.
// Latency : 2**N_IN*(SETTLE+1) edges from the start-accepting edge to table_valid; done follows for one cycle.
// Backpressure: none; start is a level honoured only in IDLE, abort cancels any active scan.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   start, abort          scan launch (level, IDLE only) and scan cancel
//   y_in                  output of the expression under test
//   vec                   input vector driven to the expression (vec[N_IN-1] = A)
//   busy, done            scan in progress, one-cycle completion pulse
//   table_out             bit i = y_in observed for vec == i
//   table_valid           table_out complete and stable
//   ones_count            number of 1 bits in table_out
//   expected, match       only when TT_COMPARE_EN is defined: reference table and
//                         registered equality result taken at the completion edge
//
// Build option: define TT_COMPARE_EN to add the expected/match compare feature.

module truth_table_scanner #(
   parameter int N_IN   = 4,
   parameter int SETTLE = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 abort,
   input  logic                 y_in,
   output logic [N_IN-1:0]      vec,
   output logic                 busy,
   output logic                 done,
   output logic [2**N_IN-1:0]   table_out,
   output logic                 table_valid,
   output logic [N_IN:0]        ones_count
`ifdef TT_COMPARE_EN
   ,
   input  logic [2**N_IN-1:0]   expected,
   output logic                 match
`endif
);

   localparam int TW = 2**N_IN;
   // Counter only has to reach SETTLE-1.
   localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SETTLE = 2'd1;
   localparam logic [1:0] S_SAMPLE = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   logic [1:0]    state;
   logic [CW-1:0] cnt;
   logic [TW-1:0] table_nxt;

   // Table including the bit captured this cycle; used both for the register
   // update and for the compare so the last sample is part of the match.
   always_comb begin
      table_nxt      = table_out;
      table_nxt[vec] = y_in;
   end

   assign busy = (state == S_SETTLE) || (state == S_SAMPLE);
   // An abort during DONE suppresses the pulse.
   assign done = (state == S_DONE) && !abort;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         cnt         <= '0;
         vec         <= '0;
         table_out   <= '0;
         table_valid <= 1'b0;
         ones_count  <= '0;
`ifdef TT_COMPARE_EN
         match       <= 1'b0;
`endif
      end else if (state == S_IDLE) begin
         vec <= '0;
         // abort has priority over start in IDLE
         if (start && !abort) begin
            state       <= S_SETTLE;
            cnt         <= '0;
            table_out   <= '0;
            table_valid <= 1'b0;
            ones_count  <= '0;
`ifdef TT_COMPARE_EN
            match       <= 1'b0;
`endif
         end
      end else if (abort) begin
         // Partial results are discarded, never reported.
         state       <= S_IDLE;
         cnt         <= '0;
         vec         <= '0;
         table_out   <= '0;
         table_valid <= 1'b0;
         ones_count  <= '0;
`ifdef TT_COMPARE_EN
         match       <= 1'b0;
`endif
      end else begin
         case (state)
            S_SETTLE: begin
               if (cnt == CNT_LAST) begin
                  state <= S_SAMPLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_SAMPLE: begin
               table_out  <= table_nxt;
               ones_count <= ones_count + (N_IN+1)'(y_in);
               if (&vec) begin
                  state       <= S_DONE;
                  table_valid <= 1'b1;
`ifdef TT_COMPARE_EN
                  match       <= (table_nxt == expected);
`endif
               end else begin
                  // vec only moves here, so every vector gets SETTLE stable cycles
                  vec   <= vec + 1'b1;
                  cnt   <= '0;
                  state <= S_SETTLE;
               end
            end
            S_DONE: begin
               vec   <= '0;
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_truth_table_scanner.sv
// Purpose : self-checking bench for truth_table_scanner (N_IN=4, SETTLE=2).
// Latency : each full scan is expected to complete 48 edges after the start edge.
// Backpressure: none; stimulus drives start/abort directly.

module tb_truth_table_scanner;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic        y_in;
   logic [3:0]  vec;
   logic        busy;
   logic        done;
   logic [15:0] table_out;
   logic        table_valid;
   logic [4:0]  ones_count;
`ifdef TT_COMPARE_EN
   logic [15:0] expected_tbl = 16'h0;
   logic        match;
`endif

   int fsel     = 0;
   int n_total  = 0;
   int n_bad    = 0;
   int done_cnt = 0;

   typedef struct {
      logic [15:0] tbl;
      logic [4:0]  ones;
      logic        m;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   truth_table_scanner #(.N_IN(4), .SETTLE(2)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .abort       (abort),
      .y_in        (y_in),
      .vec         (vec),
      .busy        (busy),
      .done        (done),
      .table_out   (table_out),
      .table_valid (table_valid),
      .ones_count  (ones_count)
`ifdef TT_COMPARE_EN
      ,
      .expected    (expected_tbl),
      .match       (match)
`endif
   );

   // Expression blocks under test: A = v[3], B = v[2], C = v[1], D = v[0].
   function automatic logic expr(int sel, logic [3:0] v);
      logic a, b, c, d;
      a = v[3]; b = v[2]; c = v[1]; d = v[0];
      case (sel)
         0:       return a | b;                        // A|B
         1:       return (a & b) | (~a & ~b & c);      // AB + A'B'C
         2:       return (~a & c) | (~b & ~d);         // A'C + B'D'
         default: return 1'b0;
      endcase
   endfunction

   assign y_in = expr(fsel, vec);

   task automatic chk(string tag, logic [31:0] got, logic [31:0] want);
      n_total++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s got=0x%0h want=0x%0h", tag, got, want);
      end
   endtask

   // Scoreboard consumer: every done pulse retires one expected result.
   always @(posedge clk) begin
      #1;
      if (rst_n && done) begin
         done_cnt++;
         if (sb.size() == 0) begin
            chk("sb_unexpected_done", 32'(sb.size()), 32'd1);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("sb_table", 32'(table_out), 32'(e.tbl));
            chk("sb_ones", 32'(ones_count), 32'(e.ones));
            chk("sb_valid", 32'(table_valid), 32'd1);
            chk("sb_busy", 32'(busy), 32'd0);
`ifdef TT_COMPARE_EN
            chk("sb_match", 32'(match), 32'(e.m));
`endif
         end
      end
   end

   // Drives start so that the next rising edge (edge 0) accepts it.
   task automatic launch(string tag, int sel, logic [15:0] tbl, logic [4:0] ones,
                         logic m, bit hold);
      exp_t e;
      @(negedge clk);
      fsel  = sel;
`ifdef TT_COMPARE_EN
      expected_tbl = (m) ? tbl : (tbl ^ 16'h0001);
`endif
      start = 1'b1;
      @(posedge clk);
      e.tbl = tbl; e.ones = ones; e.m = m;
      sb.push_back(e);
      #1;
      chk({tag, "_launch_busy"}, 32'(busy), 32'd1);
      if (!hold) start = 1'b0;
   endtask

   // mode 0: plain; 1: start pulses at edges 10 and 30; 2: abort at edge 20.
   task automatic wait_scan(string tag, int mode);
      int busy_cyc = 1;
      int done_at  = -1;
      int tv_seen  = 0;
      int d0;
      for (int k = 1; k <= 400; k++) begin
         @(posedge clk);
         #1;
         if (mode == 2 && k == 20) begin
            chk({tag, "_abort_busy"}, 32'(busy), 32'd0);
            chk({tag, "_abort_valid"}, 32'(table_valid), 32'd0);
            chk({tag, "_abort_table"}, 32'(table_out), 32'd0);
            chk({tag, "_abort_done"}, 32'(done), 32'd0);
            abort = 1'b0;
            void'(sb.pop_back());
            d0 = done_cnt;
            repeat (60) @(posedge clk);
            #2;
            chk({tag, "_abort_no_done"}, 32'(done_cnt), 32'(d0));
            return;
         end
         if (done) begin
            done_at = k;
            break;
         end
         if (busy) busy_cyc++;
         if (table_valid) tv_seen++;
         if (mode == 1) start = (k == 9 || k == 29);
         if (mode == 2 && k == 19) abort = 1'b1;
      end
      chk({tag, "_done_edge"}, 32'(done_at), 32'd48);
      chk({tag, "_busy_cycles"}, 32'(busy_cyc), 32'd48);
      chk({tag, "_valid_early"}, 32'(tv_seen), 32'd0);
   endtask

   // Checks the cycle after DONE: back in IDLE with results held.
   task automatic after_done(string tag, logic [15:0] tbl, int d_before);
      @(posedge clk);
      #2;
      chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
      chk({tag, "_idle_done"}, 32'(done), 32'd0);
      chk({tag, "_idle_vec"}, 32'(vec), 32'd0);
      chk({tag, "_one_done"}, 32'(done_cnt), 32'(d_before + 1));
      repeat (3) @(posedge clk);
      #1;
      chk({tag, "_hold_table"}, 32'(table_out), 32'(tbl));
      chk({tag, "_hold_valid"}, 32'(table_valid), 32'd1);
   endtask

   initial begin
      int d0;

      // Reset state
      #2 rst_n = 1'b0;
      #2;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_vec", 32'(vec), 32'd0);
      chk("rst_table", 32'(table_out), 32'd0);
      chk("rst_valid", 32'(table_valid), 32'd0);
      chk("rst_ones", 32'(ones_count), 32'd0);
`ifdef TT_COMPARE_EN
      chk("rst_match", 32'(match), 32'd0);
`endif
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_stays_idle", 32'(busy), 32'd0);

      // Y = A|B
      d0 = done_cnt;
      launch("aorb", 0, 16'hFFF0, 5'd12, 1'b1, 1'b0);
      wait_scan("aorb", 0);
      after_done("aorb", 16'hFFF0, d0);

      // Y = AB + A'B'C (C is the third input, D ignored)
      d0 = done_cnt;
      launch("abc", 1, 16'hF00C, 5'd6, 1'b1, 1'b0);
      wait_scan("abc", 0);
      after_done("abc", 16'hF00C, d0);

      // Y = A'C + B'D', matching and non-matching reference
      d0 = done_cnt;
      launch("acbd", 2, 16'h05CD, 5'd7, 1'b1, 1'b0);
      wait_scan("acbd", 0);
      after_done("acbd", 16'h05CD, d0);
      d0 = done_cnt;
      launch("acbd_nm", 2, 16'h05CD, 5'd7, 1'b0, 1'b0);
      wait_scan("acbd_nm", 0);
      after_done("acbd_nm", 16'h05CD, d0);

      // Asynchronous reset mid-scan at edge 20
      launch("mrst", 0, 16'hFFF0, 5'd12, 1'b1, 1'b0);
      repeat (20) @(posedge clk);
      #2 rst_n = 1'b0;
      void'(sb.pop_back());
      #1;
      chk("mrst_busy", 32'(busy), 32'd0);
      chk("mrst_vec", 32'(vec), 32'd0);
      chk("mrst_table", 32'(table_out), 32'd0);
      chk("mrst_ones", 32'(ones_count), 32'd0);
      chk("mrst_valid", 32'(table_valid), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      chk("mrst_stays_idle", 32'(busy), 32'd0);

      // Abort at edge 20, then a fresh full scan
      launch("abrt", 2, 16'h05CD, 5'd7, 1'b1, 1'b0);
      wait_scan("abrt", 2);
      d0 = done_cnt;
      launch("post_abrt", 2, 16'h05CD, 5'd7, 1'b1, 1'b0);
      wait_scan("post_abrt", 0);
      after_done("post_abrt", 16'h05CD, d0);

      // start pulses while busy are ignored
      d0 = done_cnt;
      launch("pulse", 0, 16'hFFF0, 5'd12, 1'b1, 1'b0);
      wait_scan("pulse", 1);
      after_done("pulse", 16'hFFF0, d0);

      // start held through DONE re-launches on the first IDLE cycle
      launch("hold1", 1, 16'hF00C, 5'd6, 1'b1, 1'b1);
      wait_scan("hold1", 0);
      @(posedge clk);
      #1;
      chk("hold_idle_busy", 32'(busy), 32'd0);
      chk("hold_idle_valid", 32'(table_valid), 32'd1);
      @(posedge clk);
      begin
         exp_t e;
         e.tbl = 16'hF00C; e.ones = 5'd6; e.m = 1'b1;
         sb.push_back(e);
      end
      #1;
      chk("hold_relaunch_busy", 32'(busy), 32'd1);
      chk("hold_relaunch_valid", 32'(table_valid), 32'd0);
      start = 1'b0;
      wait_scan("hold2", 0);
      repeat (2) @(posedge clk);
      #2;
      chk("sb_drained", 32'(sb.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/truth_table_scanner.md
# truth_table_scanner

Sequential driver/reader for the lab's combinational Boolean expression blocks. It steps an N-bit input vector through every combination, waits a settle interval, samples the expression output `y_in`, and assembles the complete truth table plus a minterm count. It sits between a start control (button/testbench) and one expression block, with outputs going to the LED/display logic.

## Interface
- `N_IN`, default 4: number of expression inputs (1..4). `vec[N_IN-1]` drives A, then B, C, D in order.
- `SETTLE`, default 2: cycles each vector is held before sampling (>=1).
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: level; accepted only in IDLE.
- `abort` in 1: cancels a scan in progress.
- `y_in` in 1: output of the expression under test.
- `vec` out N_IN: input vector to the expression.
- `busy` out 1: high while scanning.
- `done` out 1: one-cycle completion pulse.
- `table_out` out 2**N_IN: bit i = Y for `vec`==i.
- `table_valid` out 1: `table_out` complete and stable.
- `ones_count` out N_IN+1: number of 1 bits in the table (minterms).
- `expected` in 2**N_IN: only with `TT_COMPARE_EN`.
- `match` out 1: only with `TT_COMPARE_EN`.

## Operation
- States: IDLE, SETTLE, SAMPLE, DONE.
- Reset (async, `rst_n`=0): state IDLE; `vec`, `busy`, `done`, `table_out`, `table_valid`, `ones_count`, `match` all 0.
- IDLE: `vec`=0, `busy`=0. If `start`=1 and `abort`=0 -> SETTLE, with `vec`=0, settle counter=0, `table_out`=0, `ones_count`=0, `table_valid`=0, `match`=0.
- SETTLE: `busy`=1. Counter increments each cycle. After SETTLE cycles in this state -> SAMPLE.
- SAMPLE (1 cycle): `table_out[vec]` <= `y_in`; `ones_count` increments if `y_in`=1. If `vec`==2**N_IN-1 -> DONE and `table_valid`<=1. Otherwise `vec`++, counter=0, -> SETTLE.
- DONE (1 cycle): `done`=1, `busy`=0, `vec` reset to 0 -> IDLE.
- `y_in` is sampled only in SAMPLE and ignored in all other states.
- `abort`=1 in SETTLE, SAMPLE or DONE: go to IDLE on the next edge. `busy`=0, `table_valid`=0, no `done` pulse, partial table discarded (`table_out` cleared).
- `start` while busy is ignored. `start` held high re-launches a scan on the first IDLE cycle after DONE.
- `start` and `abort` both high in IDLE: `abort` wins and the block stays in IDLE.
- `table_out`, `ones_count` and `table_valid` hold their values after DONE until the next accepted start, abort, or reset.
- `ones_count` cannot overflow: its maximum is 2**N_IN, which fits in N_IN+1 bits.

## Timing
- Edge 0 is the edge that accepts `start`. Each vector takes SETTLE+1 edges, and the sample for vector i is taken at edge (i+1)(SETTLE+1).
- The last sample lands at edge 2**N_IN·(SETTLE+1). `table_valid` rises at that edge. `done` is high for the following cycle, and the block is back in IDLE one edge later.
- Example, N_IN=4, SETTLE=2: last sample at edge 48, `done` high between edges 48 and 49.
- `vec` changes only on SAMPLE edges, so the expression always has SETTLE full cycles of stable input before sampling.
- Reset mid-scan takes effect immediately (asynchronous). No `done` pulse, all outputs 0.

## Configuration
- `TT_COMPARE_EN` defined:
  - Adds the `expected` port and the registered `match` output.
  - `match` <= (final table == `expected`). It is computed at the completion edge, includes the last sampled bit, and is sampled alongside `table_valid`.
  - `match` is cleared on start, abort and reset.
- `TT_COMPARE_EN` undefined: neither port exists and there is no compare logic.

## Test plan
- Reset: assert `rst_n`=0 mid-scan (edge 20) -> all outputs 0 immediately. After release the block stays IDLE until `start`.
- Y=A|B, N_IN=4, SETTLE=2, single start pulse -> `done` pulses exactly once between edges 48/49, `table_out`=0xFFF0, `ones_count`=12, `busy` high for 48 cycles.
- Y=AB+A'B'C, N_IN=3 -> `table_out`=0xC2, `ones_count`=3.
- Y=A'C+B'D', N_IN=4, `TT_COMPARE_EN`:
  - `expected`=0x05CD -> `table_out`=0x05CD, `ones_count`=7, `match`=1.
  - Rerun with `expected`=0x05CC -> `match`=0.
- `abort` at edge 20 -> `busy`=0 next edge, no `done`, `table_valid`=0, `table_out`=0. A new start then yields a correct full table.
- `start` pulsed at edges 10 and 30 during a scan -> ignored, exactly one `done`. `start` held high through DONE -> second scan begins at the IDLE edge, `table_valid` drops.
